leg_ram_arbiter: RTL and testbench
==================================

Name: leg_ram_arbiter

Overview:
- Shares the single-port 256x8 LEG data RAM between the CPU load/store path and a burst DMA requester (I/O block or debug loader).
- Sits between the CPU datapath (load/save/address/data) and the RAM instance; the CPU keeps its existing combinational-read timing.
- CPU has priority. A starvation counter guarantees DMA forward progress.
- Owns the burst address pointer, beat counter and the completion handshake.

Parameters:
- STARVE_LIMIT, 3, consecutive eligible-but-lost DMA cycles before DMA is forced a beat; 0 = DMA always wins while eligible.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_load  in  1  CPU read request
- cpu_save  in  1  CPU write request
- cpu_addr  in  8  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, combinational from ram_rdata
- cpu_stall  out  1  CPU request not served this cycle; CPU must hold its request
- dma_start  in  1  one-cycle burst start pulse
- dma_we  in  1  burst direction, 1 = write to RAM; sampled at start
- dma_base  in  8  burst start address; sampled at start
- dma_len  in  8  beat count; 0 means 256; sampled at start
- dma_wdata  in  8  write-burst data
- dma_wvalid  in  1  dma_wdata valid
- dma_wready  out  1  write beat consumed this cycle
- dma_rdata  out  8  read-burst data, registered
- dma_rvalid  out  1  dma_rdata valid, one-cycle pulse per beat
- dma_busy  out  1  burst in progress
- dma_done  out  1  one-cycle pulse after the final beat
- dma_start_err  out  1  one-cycle pulse when dma_start arrives while busy
- ram_load  out  1  to RAM load
- ram_save  out  1  to RAM save
- ram_addr  out  8  to RAM address
- ram_wdata  out  8  to RAM data in
- ram_rdata  in  8  from RAM out0 (combinational read)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset state: state=IDLE. All registered outputs are 0: dma_busy, dma_done, dma_rvalid, dma_rdata, dma_start_err. The pointer, remaining count and starve_cnt are 0.
- Reset mid-burst abandons the burst. No done pulse is issued. RAM contents are unaffected.
- cpu_req = cpu_load | cpu_save. If both are high, save wins and load is ignored.
- Exactly one RAM access is granted per cycle. When nothing is granted, ram_load = ram_save = 0 and ram_addr = cpu_addr.
- States:
  - IDLE: CPU always granted, with zero latency. dma_start latches dir, ptr=dma_base and rem=(dma_len==0 ? 256 : dma_len) into a 9-bit counter, clears starve_cnt, and moves to BURST next cycle.
  - BURST: dma_busy=1.
    - dma_elig = read burst, or (write burst and dma_wvalid).
    - dma_win = dma_elig and (!cpu_req or starve_cnt >= STARVE_LIMIT).
    - If dma_win: beat at ptr. ram_save=dir, ram_load=!dir. Write beat: dma_wready=1, ram_wdata=dma_wdata. Then ptr++ (mod 256, wraps 0xFF -> 0x00), rem--, starve_cnt=0. If cpu_req, cpu_stall=1.
    - Else, if cpu_req: CPU granted. starve_cnt++ (saturating) only if dma_elig.
    - Else: no access.
    - When a beat makes rem 0: next state DONE.
  - DONE: single cycle. dma_done=1, dma_busy drops to 0 in this cycle, CPU is granted normally. Next state IDLE. A dma_start seen in DONE is honoured as in IDLE.
- Read beats: dma_rdata <= ram_rdata and dma_rvalid=1 on the cycle after the beat. The last read's rvalid coincides with dma_done.
- CPU grant: cpu_stall=0. ram_* is driven from the cpu_* inputs and cpu_rdata=ram_rdata in the same cycle. cpu_stall=1 only when cpu_req and DMA won.
- dma_start in BURST: ignored, and dma_start_err pulses the next cycle.
- Starvation bound: with STARVE_LIMIT=N and a continuous CPU request, the pattern per eligible DMA beat is N CPU cycles followed by 1 DMA cycle.

Test Plan:
- CPU only, no DMA: save 0x5A to 0x10, then load 0x10 -> cpu_rdata=0x5A in the same cycle, cpu_stall never asserted.
- Write burst, base=0x20, len=4, dma_wvalid held, no CPU activity -> 4 consecutive dma_wready beats, RAM[0x20..0x23]=wdata, dma_done exactly 1 cycle after the 4th beat, busy high for 4 cycles.
- STARVE_LIMIT=3, read burst len=2, cpu_load held continuously -> grants CPU,CPU,CPU,DMA,CPU,CPU,CPU,DMA. cpu_stall high on both DMA cycles. dma_rvalid one cycle after each DMA beat.
- Wrap and length 0:
  - base=0xFE, len=4 write -> addresses 0xFE,0xFF,0x00,0x01.
  - len=0 -> exactly 256 beats before dma_done.
- Write burst with dma_wvalid low for 3 cycles mid-burst while CPU requests -> CPU served without stall and starve_cnt does not increase. Burst resumes when wvalid returns.
- Error and reset:
  - dma_start while busy -> dma_start_err pulse, burst unchanged.
  - rst during a burst -> busy=0, no dma_done. The next dma_start works normally.

Source files
------------

// File: rtl/leg_ram_arbiter_if.sv
// leg_ram_arbiter_if: CPU, DMA and RAM-side signals of the LEG data RAM arbiter.
interface leg_ram_arbiter_if;
    logic       cpu_load;
    logic       cpu_save;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_stall;
    logic       dma_start;
    logic       dma_we;
    logic [7:0] dma_base;
    logic [7:0] dma_len;
    logic [7:0] dma_wdata;
    logic       dma_wvalid;
    logic       dma_wready;
    logic [7:0] dma_rdata;
    logic       dma_rvalid;
    logic       dma_busy;
    logic       dma_done;
    logic       dma_start_err;
    logic       ram_load;
    logic       ram_save;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    modport slave (
        input  cpu_load, cpu_save, cpu_addr, cpu_wdata,
        input  dma_start, dma_we, dma_base, dma_len, dma_wdata, dma_wvalid,
        input  ram_rdata,
        output cpu_rdata, cpu_stall,
        output dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done, dma_start_err,
        output ram_load, ram_save, ram_addr, ram_wdata
    );

    modport master (
        output cpu_load, cpu_save, cpu_addr, cpu_wdata,
        output dma_start, dma_we, dma_base, dma_len, dma_wdata, dma_wvalid,
        output ram_rdata,
        input  cpu_rdata, cpu_stall,
        input  dma_wready, dma_rdata, dma_rvalid, dma_busy, dma_done, dma_start_err,
        input  ram_load, ram_save, ram_addr, ram_wdata
    );
endinterface

// File: rtl/leg_ram_arbiter.sv
// leg_ram_arbiter: shares the single-port LEG data RAM between the CPU and a burst DMA.
// CPU wins by default; a starvation counter forces a DMA beat after STARVE_LIMIT losses.
module leg_ram_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input logic              clk,
    input logic              rst,
    leg_ram_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 2);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t          r_state, w_next;
    logic            r_dir;
    logic [7:0]      r_ptr;
    logic [8:0]      r_rem;
    logic [SW-1:0]   r_starve;
    logic            r_rvalid;
    logic [7:0]      r_rdata;
    logic            r_start_err;
    logic            w_cpu_req, w_elig, w_win, w_accept;

    assign w_cpu_req = bus.cpu_load | bus.cpu_save;
    assign w_elig    = (r_state == BURST) && (!r_dir || bus.dma_wvalid);
    assign w_win     = w_elig && (!w_cpu_req || r_starve >= SW'(STARVE_LIMIT));
    assign w_accept  = bus.dma_start && (r_state != BURST);

    always_comb begin
        w_next = w_accept ? BURST : IDLE;
        if (r_state == BURST) w_next = (w_win && r_rem == 9'd1) ? DONE : BURST;
    end

    // A losing CPU request leaves ram_* on the DMA beat; save beats load when both are high.
    assign bus.ram_load      = w_win ? !r_dir : (bus.cpu_load && !bus.cpu_save);
    assign bus.ram_save      = w_win ? r_dir : bus.cpu_save;
    assign bus.ram_addr      = w_win ? r_ptr : bus.cpu_addr;
    assign bus.ram_wdata     = w_win ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.cpu_rdata     = bus.ram_rdata;
    assign bus.cpu_stall     = w_win && w_cpu_req;
    assign bus.dma_wready    = w_win && r_dir;
    assign bus.dma_busy      = r_state == BURST;
    assign bus.dma_done      = r_state == DONE;
    assign bus.dma_rvalid    = r_rvalid;
    assign bus.dma_rdata     = r_rdata;
    assign bus.dma_start_err = r_start_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dir       <= 1'b0;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_starve    <= '0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_start_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rvalid    <= w_win && !r_dir;
            r_start_err <= bus.dma_start && r_state == BURST;
            if (w_win && !r_dir) r_rdata <= bus.ram_rdata;
            if (w_accept) begin
                r_dir    <= bus.dma_we;
                r_ptr    <= bus.dma_base;
                r_rem    <= {bus.dma_len == 8'd0, bus.dma_len};
                r_starve <= '0;
            end else if (w_win) begin
                r_ptr    <= r_ptr + 8'd1;
                r_rem    <= r_rem - 9'd1;
                r_starve <= '0;
            end else if (w_cpu_req && w_elig && r_starve < SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_leg_ram_arbiter.sv
// tb_leg_ram_arbiter: directed scenarios for leg_ram_arbiter with a 256x8 RAM model.
module tb_leg_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] mem [256];

    leg_ram_arbiter_if bus ();
    leg_ram_arbiter #(.STARVE_LIMIT(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (bus.ram_save) mem[bus.ram_addr] <= bus.ram_wdata;
    assign bus.ram_rdata = mem[bus.ram_addr];

    task automatic idle_in();
        bus.cpu_load = 1'b0;
        bus.cpu_save = 1'b0;
        bus.cpu_addr = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.dma_start = 1'b0;
        bus.dma_we = 1'b0;
        bus.dma_base = 8'h00;
        bus.dma_len = 8'h00;
        bus.dma_wdata = 8'h00;
        bus.dma_wvalid = 1'b0;
    endtask

    task automatic start_burst(input logic we, input logic [7:0] base, input logic [7:0] len);
        bus.dma_start = 1'b1;
        bus.dma_we = we;
        bus.dma_base = base;
        bus.dma_len = len;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        bus.cpu_addr = 8'h33;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({bus.dma_busy, bus.dma_done, bus.dma_rvalid, bus.dma_start_err, bus.dma_rdata} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_regs: got %h want 000", {bus.dma_busy, bus.dma_done, bus.dma_rvalid, bus.dma_start_err, bus.dma_rdata});
        end
        n_checks++;
        if ({bus.ram_load, bus.ram_save, bus.ram_addr} !== {2'b00, 8'h33}) begin
            n_fail++;
            $display("FAIL reset_ram: got %b want 0000110011", {bus.ram_load, bus.ram_save, bus.ram_addr});
        end
        rst = 1'b0;
    endtask

    task automatic test_cpu_only();
        @(negedge clk);
        bus.cpu_save = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'h5A;
        #1;
        n_checks++;
        if ({bus.cpu_stall, bus.ram_save, bus.ram_load, bus.ram_addr, bus.ram_wdata} !== {3'b010, 8'h10, 8'h5A}) begin
            n_fail++;
            $display("FAIL cpu_save: got %h want %h", {bus.cpu_stall, bus.ram_save, bus.ram_load, bus.ram_addr, bus.ram_wdata}, {3'b010, 8'h10, 8'h5A});
        end
        @(negedge clk);
        bus.cpu_save = 1'b0; bus.cpu_load = 1'b1;
        #1;
        n_checks++;
        if ({bus.cpu_stall, bus.ram_load, bus.cpu_rdata} !== {2'b01, 8'h5A}) begin
            n_fail++;
            $display("FAIL cpu_load: got %h want %h", {bus.cpu_stall, bus.ram_load, bus.cpu_rdata}, {2'b01, 8'h5A});
        end
        @(negedge clk);
        bus.cpu_save = 1'b1; bus.cpu_addr = 8'h11; bus.cpu_wdata = 8'h77;
        #1;
        n_checks++;
        if ({bus.ram_load, bus.ram_save, bus.cpu_stall} !== 3'b010) begin
            n_fail++;
            $display("FAIL cpu_save_wins: got %b want 010", {bus.ram_load, bus.ram_save, bus.cpu_stall});
        end
        @(negedge clk);
        bus.cpu_save = 1'b0;
        #1;
        n_checks++;
        if (bus.cpu_rdata !== 8'h77) begin
            n_fail++;
            $display("FAIL cpu_readback: got %h want 77", bus.cpu_rdata);
        end
        @(negedge clk);
        idle_in();
    endtask

    task automatic test_write_burst();
        @(negedge clk);
        start_burst(1'b1, 8'h20, 8'd4);
        bus.dma_wvalid = 1'b1; bus.dma_wdata = 8'hA0;
        #1;
        n_checks++;
        if ({bus.dma_busy, bus.dma_wready} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_idle: got %b want 00", {bus.dma_busy, bus.dma_wready});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.dma_start = 1'b0; bus.dma_wdata = 8'(8'hA0 + i);
            #1;
            n_checks++;
            if ({bus.dma_busy, bus.dma_wready, bus.ram_save, bus.dma_done, bus.ram_addr} !== {4'b1110, 8'(8'h20 + i)}) begin
                n_fail++;
                $display("FAIL wr_beat%0d: got %h want %h", i, {bus.dma_busy, bus.dma_wready, bus.ram_save, bus.dma_done, bus.ram_addr}, {4'b1110, 8'(8'h20 + i)});
            end
        end
        @(negedge clk);
        bus.dma_wvalid = 1'b0;
        #1;
        n_checks++;
        if ({bus.dma_busy, bus.dma_done, bus.dma_wready, bus.ram_save} !== 4'b0100) begin
            n_fail++;
            $display("FAIL wr_done: got %b want 0100", {bus.dma_busy, bus.dma_done, bus.dma_wready, bus.ram_save});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.dma_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_pulse: got %b want 0", bus.dma_done);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[8'h20 + i] !== 8'(8'hA0 + i)) begin
                n_fail++;
                $display("FAIL wr_mem%0d: got %h want %h", i, mem[8'h20 + i], 8'(8'hA0 + i));
            end
        end
        idle_in();
    endtask

    task automatic test_starvation();
        logic [7:0] pa [3];
        logic [7:0] pd [3];
        pa = '{8'h40, 8'h41, 8'h50};
        pd = '{8'h11, 8'h22, 8'h99};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.cpu_save = 1'b1; bus.cpu_addr = pa[i]; bus.cpu_wdata = pd[i];
        end
        @(negedge clk);
        idle_in();
        bus.cpu_load = 1'b1; bus.cpu_addr = 8'h50;
        start_burst(1'b0, 8'h40, 8'd2);
        #1;
        n_checks++;
        if ({bus.cpu_stall, bus.cpu_rdata} !== {1'b0, 8'h99}) begin
            n_fail++;
            $display("FAIL starve_start: got %h want 099", {bus.cpu_stall, bus.cpu_rdata});
        end
        for (int i = 1; i <= 9; i++) begin
            logic       is_d;
            logic       rv;
            logic [7:0] ea;
            logic [7:0] ed;
            @(negedge clk);
            bus.dma_start = 1'b0;
            #1;
            is_d = (i == 4) || (i == 8);
            rv = (i == 5) || (i == 9);
            ea = (i == 4) ? 8'h40 : (i == 8) ? 8'h41 : 8'h50;
            ed = (i == 5) ? 8'h11 : 8'h22;
            n_checks++;
            if ({bus.cpu_stall, bus.ram_addr} !== {is_d, ea}) begin
                n_fail++;
                $display("FAIL starve_grant%0d: got %h want %h", i, {bus.cpu_stall, bus.ram_addr}, {is_d, ea});
            end
            n_checks++;
            if ({bus.dma_rvalid, bus.dma_done} !== {rv, i == 9}) begin
                n_fail++;
                $display("FAIL starve_rvalid%0d: got %b want %b", i, {bus.dma_rvalid, bus.dma_done}, {rv, i == 9});
            end
            if (rv) begin
                n_checks++;
                if (bus.dma_rdata !== ed) begin
                    n_fail++;
                    $display("FAIL starve_rdata%0d: got %h want %h", i, bus.dma_rdata, ed);
                end
            end
        end
        idle_in();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        start_burst(1'b1, 8'hFE, 8'd4);
        bus.dma_wvalid = 1'b1; bus.dma_wdata = 8'h30;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.dma_start = 1'b0;
            #1;
            n_checks++;
            if ({bus.dma_wready, bus.ram_addr} !== {1'b1, 8'(8'hFE + i)}) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got %h want %h", i, {bus.dma_wready, bus.ram_addr}, {1'b1, 8'(8'hFE + i)});
            end
        end
        @(negedge clk);
        bus.dma_wvalid = 1'b0;
        #1;
        n_checks++;
        if (bus.dma_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: got %b want 1", bus.dma_done);
        end
        idle_in();
    endtask

    task automatic test_len0();
        int   beats = 0;
        logic seen = 1'b0;
        @(negedge clk);
        start_burst(1'b0, 8'h00, 8'd0);
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            bus.dma_start = 1'b0;
            #1;
            if (bus.dma_busy && bus.ram_load) beats++;
            if (bus.dma_done) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_done: got %b want 1 within 300 cycles", seen);
        end
        n_checks++;
        if (beats != 256) begin
            n_fail++;
            $display("FAIL len0_beats: got %0d want 256", beats);
        end
        idle_in();
    endtask

    task automatic test_wvalid_gap();
        @(negedge clk);
        start_burst(1'b1, 8'h60, 8'd3);
        bus.dma_wvalid = 1'b1; bus.dma_wdata = 8'hB0;
        @(negedge clk);
        bus.dma_start = 1'b0;
        #1;
        n_checks++;
        if ({bus.dma_wready, bus.cpu_stall, bus.ram_addr} !== {2'b10, 8'h60}) begin
            n_fail++;
            $display("FAIL gap_beat0: got %h want %h", {bus.dma_wready, bus.cpu_stall, bus.ram_addr}, {2'b10, 8'h60});
        end
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            bus.dma_wvalid = (c >= 5); bus.dma_wdata = 8'hB1;
            bus.cpu_load = 1'b1; bus.cpu_addr = 8'h10;
            #1;
            n_checks++;
            if ({bus.cpu_stall, bus.dma_wready, bus.ram_load, bus.ram_addr, bus.cpu_rdata} !== {3'b001, 8'h10, 8'h5A}) begin
                n_fail++;
                $display("FAIL gap_cpu%0d: got %h want %h", c, {bus.cpu_stall, bus.dma_wready, bus.ram_load, bus.ram_addr, bus.cpu_rdata}, {3'b001, 8'h10, 8'h5A});
            end
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.cpu_stall, bus.dma_wready, bus.ram_save, bus.ram_addr} !== {3'b111, 8'h61}) begin
            n_fail++;
            $display("FAIL gap_forced: got %h want %h", {bus.cpu_stall, bus.dma_wready, bus.ram_save, bus.ram_addr}, {3'b111, 8'h61});
        end
        @(negedge clk);
        bus.cpu_load = 1'b0; bus.dma_wdata = 8'hB2;
        #1;
        n_checks++;
        if ({bus.dma_wready, bus.ram_addr} !== {1'b1, 8'h62}) begin
            n_fail++;
            $display("FAIL gap_last: got %h want %h", {bus.dma_wready, bus.ram_addr}, {1'b1, 8'h62});
        end
        @(negedge clk);
        bus.dma_wvalid = 1'b0;
        #1;
        n_checks++;
        if ({bus.dma_done, mem[8'h60], mem[8'h61], mem[8'h62]} !== {1'b1, 8'hB0, 8'hB1, 8'hB2}) begin
            n_fail++;
            $display("FAIL gap_mem: got %h want %h", {bus.dma_done, mem[8'h60], mem[8'h61], mem[8'h62]}, {1'b1, 8'hB0, 8'hB1, 8'hB2});
        end
        idle_in();
    endtask

    task automatic test_start_err();
        @(negedge clk);
        start_burst(1'b1, 8'h80, 8'd2);
        @(negedge clk);
        start_burst(1'b0, 8'h90, 8'd5);
        #1;
        n_checks++;
        if ({bus.dma_busy, bus.dma_start_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_busy: got %b want 10", {bus.dma_busy, bus.dma_start_err});
        end
        @(negedge clk);
        bus.dma_start = 1'b0; bus.dma_wvalid = 1'b1; bus.dma_wdata = 8'hC0;
        #1;
        n_checks++;
        if ({bus.dma_start_err, bus.dma_wready, bus.ram_addr} !== {2'b11, 8'h80}) begin
            n_fail++;
            $display("FAIL err_pulse: got %h want %h", {bus.dma_start_err, bus.dma_wready, bus.ram_addr}, {2'b11, 8'h80});
        end
        @(negedge clk);
        bus.dma_wdata = 8'hC1;
        #1;
        n_checks++;
        if ({bus.dma_start_err, bus.dma_wready, bus.ram_addr} !== {2'b01, 8'h81}) begin
            n_fail++;
            $display("FAIL err_cont: got %h want %h", {bus.dma_start_err, bus.dma_wready, bus.ram_addr}, {2'b01, 8'h81});
        end
        @(negedge clk);
        bus.dma_wvalid = 1'b0;
        #1;
        n_checks++;
        if ({bus.dma_done, bus.dma_busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_done: got %b want 10", {bus.dma_done, bus.dma_busy});
        end
        idle_in();
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        start_burst(1'b1, 8'hA0, 8'd5);
        bus.dma_wvalid = 1'b1; bus.dma_wdata = 8'hE0;
        @(negedge clk);
        bus.dma_start = 1'b0;
        @(negedge clk);
        bus.dma_wdata = 8'hE1;
        @(negedge clk);
        bus.dma_wvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.dma_busy, bus.dma_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid: got %b want 00", {bus.dma_busy, bus.dma_done});
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({bus.dma_busy, bus.dma_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_nodone%0d: got %b want 00", c, {bus.dma_busy, bus.dma_done});
            end
        end
        @(negedge clk);
        start_burst(1'b0, 8'hA0, 8'd1);
        @(negedge clk);
        bus.dma_start = 1'b0;
        #1;
        n_checks++;
        if ({bus.dma_busy, bus.ram_load, bus.ram_addr} !== {2'b11, 8'hA0}) begin
            n_fail++;
            $display("FAIL rst_restart: got %h want %h", {bus.dma_busy, bus.ram_load, bus.ram_addr}, {2'b11, 8'hA0});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.dma_done, bus.dma_rvalid, bus.dma_rdata} !== {2'b11, 8'hE0}) begin
            n_fail++;
            $display("FAIL rst_reread: got %h want %h", {bus.dma_done, bus.dma_rvalid, bus.dma_rdata}, {2'b11, 8'hE0});
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_write_burst();
        test_starvation();
        test_wrap();
        test_len0();
        test_wvalid_gap();
        test_start_err();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
